// File: rtl/atctlc2axi500_arb_rr_lock_if.sv
// Handshake bundle between N upstream requesters and the shared downstream channel
// of atctlc2axi500_arb_rr_lock. The arbiter uses the master modport.
interface atctlc2axi500_arb_rr_lock_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 32,
  parameter int unsigned IW = 2
);
  logic [N-1:0]    valids;
  logic [N-1:0]    lasts;
  logic [N*DW-1:0] datas;
  logic [N-1:0]    readys;
  logic [N-1:0]    grants;
  logic            valid;
  logic            last;
  logic [DW-1:0]   data;
  logic            ready;
  logic [IW-1:0]   gnt_idx;
  logic            locked;

  modport master (
    input  valids, lasts, datas, ready,
    output readys, grants, valid, last, data, gnt_idx, locked
  );

  modport slave (
    output valids, lasts, datas, ready,
    input  readys, grants, valid, last, data, gnt_idx, locked
  );
endinterface

// File: rtl/atctlc2axi500_arb_rr_lock.sv
// Round-robin valid/ready arbiter with burst locking; purely combinational datapath.
// Define ATCTLC2AXI500_ARB_RR_EN for rotating priority; otherwise fixed priority (bit 0 highest).
module atctlc2axi500_arb_rr_lock #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 32,
  parameter int unsigned IW = 2
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  atctlc2axi500_arb_rr_lock_if.master     bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] lock_id_q, lock_id_d;
  logic [IW-1:0] ptr;

  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic [N-1:0]  grants_c;
  logic          valid_c;
  logic [IW-1:0] gnt_idx_c;
  logic [DW-1:0] data_c;
  logic          last_c;
  logic          xfer;

  // First set bit of valids searching upward from ptr, wrapping N-1 -> 0.
  always_comb begin
    int unsigned cand;
    logic [IW-1:0] cand_idx;
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand     = (32'(ptr) + k) % N;
      cand_idx = IW'(cand);
      if (!win_vld && bus.valids[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_comb begin
    grants_c  = '0;
    valid_c   = 1'b0;
    gnt_idx_c = '0;
    if (state_q == LOCKED) begin
      valid_c   = bus.valids[lock_id_q];
      grants_c  = valid_c ? (N'(1) << lock_id_q) : '0;
      gnt_idx_c = lock_id_q;
    end else begin
      valid_c   = |bus.valids;
      grants_c  = win_vld ? (N'(1) << win_idx) : '0;
      gnt_idx_c = win_idx;
    end
  end

  // One-hot OR mux keeps data and last at zero when nothing is granted.
  always_comb begin
    data_c = '0;
    last_c = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grants_c[k]) begin
        data_c = data_c | bus.datas[k*DW +: DW];
        last_c = last_c | bus.lasts[k];
      end
    end
  end

  assign xfer = valid_c & bus.ready;

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      IDLE: begin
        if (xfer && !last_c) begin
          state_d   = LOCKED;
          lock_id_d = win_idx;
        end
      end
      LOCKED: begin
        if (xfer && last_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

`ifdef ATCTLC2AXI500_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // gnt_idx is the winner in IDLE and lock_id in LOCKED, so one rule covers both states.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && last_c) begin
      ptr_d = (gnt_idx_c == IW'(N-1)) ? '0 : gnt_idx_c + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  assign bus.grants  = grants_c;
  assign bus.readys  = grants_c & {N{bus.ready}};
  assign bus.valid   = valid_c;
  assign bus.last    = last_c;
  assign bus.data    = data_c;
  assign bus.gnt_idx = gnt_idx_c;
  assign bus.locked  = (state_q == LOCKED);

endmodule
